// File: rtl/assoc_cache_ctrl.sv
// assoc_cache_ctrl: control FSM for an N-way set-associative, write-back,
// write-allocate cache. It takes per-way hit/valid/dirty vectors from external
// tag arrays, picks victims with an invalid-first / tree pseudo-LRU policy, and
// sequences multi-beat write-back and refill bursts.
// Optional feature: define ASSOC_CACHE_PERF_EN to add saturating hit/miss/
// write-back event counters (hit_cnt, miss_cnt, wb_cnt).
// Event outputs (cpu_ready, way_wen, set_dirty, set_valid, clr_dirty) are
// registered. They appear one cycle after the state that raises them, so a
// refill beat's way_wen follows its mem_resp by one cycle. Level outputs
// (busy, mem_read, mem_write) are registered from the next state, so they
// line up with the state they describe.
module assoc_cache_ctrl #(
    parameter int WAYS  = 4,
    parameter int SETS  = 16,
    parameter int BEATS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [$clog2(SETS)-1:0]   cpu_set,
    input  logic [WAYS-1:0]           way_hit,
    input  logic [WAYS-1:0]           way_valid,
    input  logic [WAYS-1:0]           way_dirty,
    input  logic                      mem_resp,
    output logic                      cpu_ready,
    output logic [WAYS-1:0]           way_wen,
    output logic                      set_dirty,
    output logic                      clr_dirty,
    output logic                      set_valid,
    output logic [$clog2(WAYS)-1:0]   victim_way,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [$clog2(BEATS):0]    mem_beat,
    output logic                      busy
`ifdef ASSOC_CACHE_PERF_EN
    ,
    output logic [31:0]               hit_cnt,
    output logic [31:0]               miss_cnt,
    output logic [31:0]               wb_cnt
`endif
);

    localparam int WAY_W  = $clog2(WAYS);
    localparam int SET_W  = $clog2(SETS);
    localparam int BEAT_W = $clog2(BEATS) + 1;
    localparam int LVLS   = WAY_W;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COMPARE   = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_ALLOCATE  = 3'd3,
        ST_FILL_DONE = 3'd4
    } state_t;

    // Index of the lowest set bit (0 when the vector is empty).
    function automatic logic [WAY_W-1:0] lowest_set(input logic [WAYS-1:0] vec);
        logic [WAY_W-1:0] idx;
        idx = {WAY_W{1'b0}};
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (vec[i]) idx = WAY_W'(i);
        end
        return idx;
    endfunction

    // One-hot way vector from a way index.
    function automatic logic [WAYS-1:0] onehot(input logic [WAY_W-1:0] idx);
        return {{(WAYS-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Walk the tree from the root. A 0 bit goes to the lower half and a 1 bit
    // goes to the upper half. Nodes are heap ordered: children of n are 2n+1
    // and 2n+2.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
        logic [WAY_W-1:0] way;
        logic [WAY_W-1:0] node;
        way  = {WAY_W{1'b0}};
        node = {WAY_W{1'b0}};
        for (int l = 0; l < LVLS; l++) begin
            way  = WAY_W'({way, bits[node]});
            node = WAY_W'({node, 1'b0}) + WAY_W'(1'b1) + WAY_W'(bits[node]);
        end
        return way;
    endfunction

    // Point every node on the accessed way's path away from that way.
    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                   input logic [WAY_W-1:0] way);
        logic [WAYS-2:0]  nb;
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] w;
        logic             d;
        nb   = bits;
        node = {WAY_W{1'b0}};
        w    = way;
        for (int l = 0; l < LVLS; l++) begin
            d        = w[WAY_W-1];
            nb[node] = ~d;
            node     = WAY_W'({node, 1'b0}) + WAY_W'(1'b1) + WAY_W'(d);
            w        = w << 1;
        end
        return nb;
    endfunction

    state_t             state_r, state_next_s;
    logic [BEAT_W-1:0]  beat_r, beat_next_s;
    logic [WAY_W-1:0]   victim_r, victim_next_s;
    logic [SET_W-1:0]   set_r;
    logic               we_r;
    logic [WAYS-2:0]    plru_r [SETS];

    logic               ready_s, set_dirty_s, clr_dirty_s, set_valid_s;
    logic [WAYS-1:0]    wen_s;
    logic               plru_we_s;
    logic [WAY_W-1:0]   plru_way_s;
    logic [WAY_W-1:0]   hit_idx_s;
    logic [WAY_W-1:0]   pick_s;
    logic               last_beat_s;

    logic               cpu_ready_r, set_dirty_r, clr_dirty_r, set_valid_r;
    logic [WAYS-1:0]    way_wen_r;
    logic               mem_read_r, mem_write_r, busy_r;

    assign hit_idx_s   = lowest_set(way_hit);
    assign pick_s      = (&way_valid) ? plru_victim(plru_r[set_r]) : lowest_set(~way_valid);
    assign last_beat_s = (beat_r == BEAT_W'(BEATS - 1));

    // Next-state, beat counter, victim selection and event strobes.
    always_comb begin
        state_next_s  = state_r;
        beat_next_s   = beat_r;
        victim_next_s = victim_r;
        ready_s       = 1'b0;
        wen_s         = {WAYS{1'b0}};
        set_dirty_s   = 1'b0;
        clr_dirty_s   = 1'b0;
        set_valid_s   = 1'b0;
        plru_we_s     = 1'b0;
        plru_way_s    = victim_r;
        case (state_r)
            ST_IDLE: begin
                if (cpu_req) state_next_s = ST_COMPARE;
                else         state_next_s = ST_IDLE;
            end
            ST_COMPARE: begin
                if (|way_hit) begin
                    ready_s      = 1'b1;
                    plru_we_s    = 1'b1;
                    plru_way_s   = hit_idx_s;
                    state_next_s = ST_IDLE;
                    if (we_r) begin
                        wen_s       = onehot(hit_idx_s);
                        set_dirty_s = 1'b1;
                    end else begin
                        wen_s       = {WAYS{1'b0}};
                        set_dirty_s = 1'b0;
                    end
                end else begin
                    victim_next_s = pick_s;
                    beat_next_s   = {BEAT_W{1'b0}};
                    if (way_valid[pick_s] && way_dirty[pick_s]) state_next_s = ST_WRITEBACK;
                    else                                        state_next_s = ST_ALLOCATE;
                end
            end
            ST_WRITEBACK: begin
                if (mem_resp) begin
                    if (last_beat_s) begin
                        beat_next_s  = {BEAT_W{1'b0}};
                        state_next_s = ST_ALLOCATE;
                    end else begin
                        beat_next_s  = beat_r + BEAT_W'(1'b1);
                    end
                end else begin
                    beat_next_s = beat_r;
                end
            end
            ST_ALLOCATE: begin
                if (mem_resp) begin
                    wen_s = onehot(victim_r);
                    if (last_beat_s) begin
                        beat_next_s  = {BEAT_W{1'b0}};
                        state_next_s = ST_FILL_DONE;
                    end else begin
                        beat_next_s  = beat_r + BEAT_W'(1'b1);
                    end
                end else begin
                    beat_next_s = beat_r;
                end
            end
            ST_FILL_DONE: begin
                set_valid_s  = 1'b1;
                clr_dirty_s  = 1'b1;
                plru_we_s    = 1'b1;
                plru_way_s   = victim_r;
                state_next_s = ST_COMPARE;
            end
            default: begin
                state_next_s = ST_IDLE;
                beat_next_s  = {BEAT_W{1'b0}};
            end
        endcase
    end

    // State, request latches and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            beat_r      <= {BEAT_W{1'b0}};
            victim_r    <= {WAY_W{1'b0}};
            set_r       <= {SET_W{1'b0}};
            we_r        <= 1'b0;
            cpu_ready_r <= 1'b0;
            way_wen_r   <= {WAYS{1'b0}};
            set_dirty_r <= 1'b0;
            clr_dirty_r <= 1'b0;
            set_valid_r <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            beat_r      <= beat_next_s;
            victim_r    <= victim_next_s;
            if (state_r == ST_IDLE && cpu_req) begin
                set_r <= cpu_set;
                we_r  <= cpu_we;
            end else begin
                set_r <= set_r;
                we_r  <= we_r;
            end
            cpu_ready_r <= ready_s;
            way_wen_r   <= wen_s;
            set_dirty_r <= set_dirty_s;
            clr_dirty_r <= clr_dirty_s;
            set_valid_r <= set_valid_s;
            mem_read_r  <= (state_next_s == ST_ALLOCATE);
            mem_write_r <= (state_next_s == ST_WRITEBACK);
            busy_r      <= (state_next_s != ST_IDLE);
        end
    end

    // Per-set pseudo-LRU tree bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) plru_r[s] <= {(WAYS-1){1'b0}};
        end else if (plru_we_s) begin
            plru_r[set_r] <= plru_touch(plru_r[set_r], plru_way_s);
        end else begin
            plru_r[set_r] <= plru_r[set_r];
        end
    end

    assign cpu_ready  = cpu_ready_r;
    assign way_wen    = way_wen_r;
    assign set_dirty  = set_dirty_r;
    assign clr_dirty  = clr_dirty_r;
    assign set_valid  = set_valid_r;
    assign victim_way = victim_r;
    assign mem_read   = mem_read_r;
    assign mem_write  = mem_write_r;
    assign mem_beat   = beat_r;
    assign busy       = busy_r;

`ifdef ASSOC_CACHE_PERF_EN
    logic        recompare_r;
    logic [31:0] hit_cnt_r, miss_cnt_r, wb_cnt_r;

    // Event counters. COMPARE directly after FILL_DONE is the re-compare and
    // is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            recompare_r <= 1'b0;
            hit_cnt_r   <= 32'd0;
            miss_cnt_r  <= 32'd0;
            wb_cnt_r    <= 32'd0;
        end else begin
            recompare_r <= (state_r == ST_FILL_DONE);
            if (state_r == ST_COMPARE && !recompare_r && (|way_hit) && hit_cnt_r != 32'hFFFF_FFFF)
                hit_cnt_r <= hit_cnt_r + 32'd1;
            else
                hit_cnt_r <= hit_cnt_r;
            if (state_r == ST_COMPARE && !recompare_r && !(|way_hit) && miss_cnt_r != 32'hFFFF_FFFF)
                miss_cnt_r <= miss_cnt_r + 32'd1;
            else
                miss_cnt_r <= miss_cnt_r;
            if (state_r == ST_COMPARE && state_next_s == ST_WRITEBACK && wb_cnt_r != 32'hFFFF_FFFF)
                wb_cnt_r <= wb_cnt_r + 32'd1;
            else
                wb_cnt_r <= wb_cnt_r;
        end
    end

    assign hit_cnt  = hit_cnt_r;
    assign miss_cnt = miss_cnt_r;
    assign wb_cnt   = wb_cnt_r;
`endif

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Self-checking bench for assoc_cache_ctrl (WAYS=4, SETS=16, BEATS=4).
// The reference keeps, per set, which half was touched most recently and which
// member of each pair was touched most recently; the victim is the other
// member of the other pair.
module tb_assoc_cache_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpu_req = 1'b0;
    logic       cpu_we = 1'b0;
    logic [3:0] cpu_set = 4'd0;
    logic [3:0] way_hit = 4'd0;
    logic [3:0] way_valid = 4'd0;
    logic [3:0] way_dirty = 4'd0;
    logic       mem_resp = 1'b0;
    logic       cpu_ready, set_dirty, clr_dirty, set_valid, mem_read, mem_write, busy;
    logic [3:0] way_wen;
    logic [1:0] victim_way;
    logic [2:0] mem_beat;
`ifdef ASSOC_CACHE_PERF_EN
    logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int mru_half [16];
    int mru_pair [16][2];
    int exp_hits = 0, exp_misses = 0, exp_wbs = 0;

    assoc_cache_ctrl #(.WAYS(4), .SETS(16), .BEATS(4)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_set(cpu_set),
        .way_hit(way_hit), .way_valid(way_valid), .way_dirty(way_dirty),
        .mem_resp(mem_resp), .cpu_ready(cpu_ready), .way_wen(way_wen),
        .set_dirty(set_dirty), .clr_dirty(clr_dirty), .set_valid(set_valid),
        .victim_way(victim_way), .mem_read(mem_read), .mem_write(mem_write),
        .mem_beat(mem_beat), .busy(busy)
`ifdef ASSOC_CACHE_PERF_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int s = 0; s < 16; s++) begin
            mru_half[s]    = 1;
            mru_pair[s][0] = 1;
            mru_pair[s][1] = 1;
        end
        exp_hits = 0; exp_misses = 0; exp_wbs = 0;
    endfunction

    function automatic void model_touch(input int s, input int w);
        mru_half[s]        = w / 2;
        mru_pair[s][w / 2] = w % 2;
    endfunction

    function automatic int model_victim(input int s);
        int p;
        p = 1 - mru_half[s];
        return 2 * p + (1 - mru_pair[s][p]);
    endfunction

    function automatic int low1(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [3:0] oh(input int w);
        logic [3:0] v;
        v = 4'd0;
        v[w] = 1'b1;
        return v;
    endfunction

    // One complete CPU access from IDLE back to IDLE, checked cycle by cycle.
    task automatic run_access(input int s, input bit we, input logic [3:0] hit,
                              input logic [3:0] valid, input logic [3:0] dirty,
                              input int max_stall, input int stall_at, input bit spur);
        int ev, hw, st;
        bit wb;
        logic [11:0] act, expv;
        cpu_req = 1'b1; cpu_we = we; cpu_set = 4'(s);
        way_hit = hit; way_valid = valid; way_dirty = dirty;
        mem_resp = spur ? 1'($urandom) : 1'b0;
        tick();
        n_checks++;
        if ({busy, cpu_ready, mem_read, mem_write} !== 4'b1000) begin
            n_fail++;
            $display("FAIL compare_entry: got %b expected 1000", {busy, cpu_ready, mem_read, mem_write});
        end
        cpu_req  = spur ? 1'($urandom) : 1'b0;
        if (spur) begin cpu_we = ~we; cpu_set = 4'($urandom); end
        mem_resp = spur ? 1'($urandom) : 1'b0;
        tick();
        if (hit != 4'd0) begin
            hw = low1(hit);
            model_touch(s, hw);
            exp_hits++;
            act  = {3'd0, cpu_ready, way_wen, set_dirty, busy, mem_read, mem_write};
            expv = {3'd0, 1'b1, (we ? oh(hw) : 4'd0), we, 1'b0, 1'b0, 1'b0};
            n_checks++;
            if (act !== expv) begin
                n_fail++;
                $display("FAIL hit_done set=%0d we=%0d: got %h expected %h", s, we, act, expv);
            end
            cpu_req = 1'b0; mem_resp = 1'b0;
            return;
        end
        exp_misses++;
        ev = (valid != 4'hF) ? low1(~valid) : model_victim(s);
        wb = valid[ev] && dirty[ev];
        act  = {victim_way, mem_write, mem_read, mem_beat, cpu_ready, way_wen};
        expv = {2'(ev), wb, !wb, 3'd0, 1'b0, 4'd0};
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL miss_entry set=%0d: got %h expected %h", s, act, expv);
        end
        if (wb) exp_wbs++;
        for (int p = (wb ? 0 : 1); p < 2; p++) begin
            for (int b = 0; b < 4; b++) begin
                st = (b == stall_at) ? 3 : ((max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0);
                for (int k = 0; k < st; k++) begin
                    mem_resp = 1'b0;
                    cpu_req  = spur ? 1'($urandom) : 1'b0;
                    tick();
                    act  = {3'd0, mem_write, mem_read, mem_beat, way_wen};
                    expv = {3'd0, (p == 0), (p == 1), 3'(b), 4'd0};
                    n_checks++;
                    if (act !== expv) begin
                        n_fail++;
                        $display("FAIL burst_stall p=%0d beat=%0d: got %h expected %h", p, b, act, expv);
                    end
                end
                mem_resp = 1'b1;
                tick();
                mem_resp = 1'b0;
                act  = {2'd0, busy, mem_write, mem_read, mem_beat, way_wen};
                expv = {2'd0, 1'b1, (b < 3) ? (p == 0) : 1'b0, (b < 3) ? (p == 1) : (p == 0),
                        (b < 3) ? 3'(b + 1) : 3'd0, (p == 1) ? oh(ev) : 4'd0};
                n_checks++;
                if (act !== expv) begin
                    n_fail++;
                    $display("FAIL burst_beat p=%0d beat=%0d: got %h expected %h", p, b, act, expv);
                end
            end
        end
        way_hit  = oh(ev);
        mem_resp = spur ? 1'($urandom) : 1'b0;
        cpu_req  = spur ? 1'($urandom) : 1'b0;
        tick();
        model_touch(s, ev);
        act  = {3'd0, set_valid, clr_dirty, victim_way, busy, cpu_ready, way_wen};
        expv = {3'd0, 1'b1, 1'b1, 2'(ev), 1'b1, 1'b0, 4'd0};
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL fill_done set=%0d: got %h expected %h", s, act, expv);
        end
        mem_resp = spur ? 1'($urandom) : 1'b0;
        cpu_req  = spur ? 1'($urandom) : 1'b0;
        tick();
        act  = {2'd0, cpu_ready, way_wen, set_dirty, set_valid, clr_dirty, busy};
        expv = {2'd0, 1'b1, (we ? oh(ev) : 4'd0), we, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL recompare set=%0d we=%0d: got %h expected %h", s, we, act, expv);
        end
        cpu_req = 1'b0; mem_resp = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        n_checks++;
        if ({cpu_ready, way_wen, set_dirty, clr_dirty, set_valid, victim_way, mem_read,
             mem_write, mem_beat, busy} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", {cpu_ready, way_wen, set_dirty,
                     clr_dirty, set_valid, victim_way, mem_read, mem_write, mem_beat, busy});
        end
        rst = 1'b0;
        model_reset();
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_read_hit();
        run_access(3, 1'b0, 4'b0100, 4'b1111, 4'b0000, 0, -1, 1'b0);
        // A full clean set-3 miss afterwards must not evict the way just read.
        run_access(3, 1'b0, 4'b0000, 4'b1111, 4'b0000, 0, -1, 1'b0);
        n_checks++;
        if (victim_way === 2'd2) begin
            n_fail++;
            $display("FAIL plru_after_hit: victim got %0d, required anything but 2", victim_way);
        end
    endtask

    task automatic test_write_hit();
        run_access(3, 1'b1, 4'b0010, 4'b1111, 4'b0000, 0, -1, 1'b0);
    endtask

    task automatic test_miss_invalid();
        run_access(4, 1'b0, 4'b0000, 4'b1011, 4'b0100, 0, -1, 1'b0);
    endtask

    task automatic test_writeback_stall();
        run_access(7, 1'b1, 4'b0000, 4'b1111, 4'b0001, 0, 2, 1'b0);
    endtask

    task automatic test_fill_set();
        logic [3:0] v;
        v = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            run_access(5, 1'b0, 4'b0000, v, 4'b0000, 0, -1, 1'b0);
            v[i] = 1'b1;
        end
        run_access(5, 1'b0, 4'b0000, 4'b1111, 4'b0000, 0, -1, 1'b0);
        n_checks++;
        if (victim_way !== 2'd0) begin
            n_fail++;
            $display("FAIL fill_set_victim: got %0d expected 0", victim_way);
        end
    endtask

    task automatic test_reset_mid_burst();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_set = 4'd9;
        way_hit = 4'd0; way_valid = 4'b0001; way_dirty = 4'd0;
        tick();
        cpu_req = 1'b0;
        tick();
        mem_resp = 1'b1;
        tick(); tick();
        mem_resp = 1'b1;
        n_checks++;
        if ({mem_read, mem_beat, victim_way} !== {1'b1, 3'd2, 2'd1}) begin
            n_fail++;
            $display("FAIL pre_reset_beat: got %h expected %h", {mem_read, mem_beat, victim_way}, {1'b1, 3'd2, 2'd1});
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if ({cpu_ready, way_wen, set_dirty, clr_dirty, set_valid, victim_way, mem_read,
             mem_write, mem_beat, busy} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid_burst: got %h expected 0", {cpu_ready, way_wen, set_dirty,
                     clr_dirty, set_valid, victim_way, mem_read, mem_write, mem_beat, busy});
        end
        rst = 1'b0; mem_resp = 1'b0;
        model_reset();
        tick(); tick();
        n_checks++;
        if ({set_valid, clr_dirty, cpu_ready, busy, mem_read} !== 5'd0) begin
            n_fail++;
            $display("FAIL post_reset_quiet: got %b expected 00000", {set_valid, clr_dirty, cpu_ready, busy, mem_read});
        end
    endtask

    task automatic test_random();
        logic [3:0] hv, vv;
        for (int t = 0; t < 120; t++) begin
            hv = ($urandom_range(2, 0) == 0) ? oh(int'($urandom_range(3, 0))) : 4'd0;
            vv = ($urandom_range(3, 0) != 0) ? 4'hF : 4'($urandom);
            run_access(int'($urandom_range(3, 0)), 1'($urandom), hv, vv, 4'($urandom), 2, -1, 1'b1);
        end
    endtask

    task automatic test_perf();
`ifdef ASSOC_CACHE_PERF_EN
        n_checks++;
        if ({hit_cnt, miss_cnt, wb_cnt} !== {32'(exp_hits), 32'(exp_misses), 32'(exp_wbs)}) begin
            n_fail++;
            $display("FAIL perf_counters: got %0d/%0d/%0d expected %0d/%0d/%0d",
                     hit_cnt, miss_cnt, wb_cnt, exp_hits, exp_misses, exp_wbs);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_write_hit();
        test_miss_invalid();
        test_writeback_stall();
        test_fill_set();
        test_reset_mid_burst();
        test_random();
        test_perf();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
